// File: rtl/s1_vec_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : s1_pkg
// Purpose  : Shared types and constants for the stage-1 vector loader slice.
//            Q12.20 fixed-point word format, loader FSM states and a
//            constant-safe ceil(log2) helper.
// Revision : 1.0  initial release
// ============================================================================
package s1_pkg;

    localparam int N_BITS    = 32;
    localparam int INT_BITS  = 12;
    localparam int FRAC_BITS = 20;
    localparam int M_IN      = 8;

    typedef logic signed [N_BITS-1:0] fix_t;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } loader_state_t;

    // ceil(log2(v)); returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/s1_vec_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : s1_vec_loader_if
// Purpose  : Groups the serial-sample side and the parallel-vector side of
//            the loader.
//   Serial : in_data, in_valid, in_last  (producer -> loader), in_ready back
//   Vector : X, vec_valid, vec_count, short_vec (loader -> consumer),
//            vec_ready back
//   Modports: slave  = loader view
//             master = environment (producer + consumer) view
// Revision : 1.0  initial release
// ============================================================================
interface s1_vec_loader_if
    import s1_pkg::*;
#(
    parameter int M  = M_IN,
    parameter int N  = N_BITS,
    parameter int CW = clog2(M + 1)
);
    logic [N-1:0]   in_data;
    logic           in_valid;
    logic           in_last;
    logic           in_ready;
    logic [M*N-1:0] X;
    logic           vec_valid;
    logic           vec_ready;
    logic [CW-1:0]  vec_count;
    logic           short_vec;

    modport slave (
        input  in_data, in_valid, in_last, vec_ready,
        output in_ready, X, vec_valid, vec_count, short_vec
    );

    modport master (
        output in_data, in_valid, in_last, vec_ready,
        input  in_ready, X, vec_valid, vec_count, short_vec
    );
endinterface
`default_nettype wire

// File: rtl/s1_vec_loader_bank.sv
`default_nettype none
// ============================================================================
// Module   : s1_vec_bank
// Purpose  : One M-word vector register with a write index. Each write
//            stores a word at the current slot; the write that lands on the
//            last slot, or carries i_last, closes the vector: higher slots
//            are zeroed in the same cycle, the sample count and short flag
//            are captured and the index rewinds to 0.
//   Ports  : clk, rst        clock / synchronous active-high reset
//            i_wr_en         a sample is transferred into this bank
//            i_data, i_last  sample word and end-of-vector marker
//            o_close         this write closes the vector (combinational)
//            o_words         stored vector, word k at [N*(k+1)-1 -: N]
//            o_count         samples in the last closed vector
//            o_short         last closed vector ended before slot M-1
// Revision : 1.0  initial release
// ============================================================================
module s1_vec_bank
    import s1_pkg::*;
#(
    parameter int M  = M_IN,
    parameter int N  = N_BITS,
    parameter int CW = clog2(M + 1)
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           i_wr_en,
    input  wire logic [N-1:0]   i_data,
    input  wire logic           i_last,
    output logic                o_close,
    output logic [M*N-1:0]      o_words,
    output logic [CW-1:0]       o_count,
    output logic                o_short
);

    localparam int IW = (clog2(M) < 1) ? 1 : clog2(M);
    localparam logic [IW-1:0] c_last_idx = IW'(M - 1);

    logic [M*N-1:0] r_words;
    logic [IW-1:0]  r_idx;
    logic [CW-1:0]  r_count;
    logic           r_short;
    logic           w_close;

    assign w_close = i_wr_en && ((r_idx == c_last_idx) || i_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_words <= '0;
            r_idx   <= '0;
            r_count <= '0;
            r_short <= 1'b0;
        end else if (i_wr_en) begin
            for (int k = 0; k < M; k++) begin
                if (k == int'(r_idx)) begin
                    r_words[N*k +: N] <= i_data;
                end else if (w_close && (k > int'(r_idx))) begin
                    r_words[N*k +: N] <= '0;
                end
            end
            if (w_close) begin
                r_idx   <= '0;
                r_count <= CW'(r_idx) + CW'(1);
                r_short <= (r_idx != c_last_idx);
            end else begin
                r_idx   <= r_idx + IW'(1);
            end
        end
    end

    assign o_close = w_close;
    assign o_words = r_words;
    assign o_count = r_count;
    assign o_short = r_short;

endmodule
`default_nettype wire

// File: rtl/s1_vec_loader.sv
`default_nettype none
// ============================================================================
// Module   : s1_vec_loader
// Purpose  : Collects serial Q12.20 samples into an M-word vector and
//            presents it on X, held stable until the consumer accepts it.
//            Words are passed through untouched.
//   Ports  : clk, rst  clock / synchronous active-high reset
//            bus       s1_vec_loader_if.slave (serial in, vector out)
//   Build option: VEC_LOADER_DBUF_EN
//            undefined - single bank, FILL/HOLD sequencing
//            defined   - ping/pong banks, one fills while the other is
//                        presented; in_ready drops only when both are full
// Revision : 1.0  initial release
// ============================================================================
module s1_vec_loader
    import s1_pkg::*;
#(
    parameter int M  = M_IN,
    parameter int N  = N_BITS,
    parameter int CW = clog2(M + 1)
) (
    input  wire logic        clk,
    input  wire logic        rst,
    s1_vec_loader_if.slave   bus
);

`ifdef VEC_LOADER_DBUF_EN

    logic [1:0]     r_full;
    logic           r_fill_sel;
    logic           r_pres_sel;
    logic           w_in_ready;
    logic           w_xfer_in;
    logic           w_xfer_out;
    logic [1:0]     w_close;
    logic [M*N-1:0] w_words [2];
    logic [CW-1:0]  w_count [2];
    logic [1:0]     w_short;

    // The fill pointer always rests on a non-full bank whenever one exists,
    // so "any bank free" is exactly "the fill bank can take a sample".
    assign w_in_ready = ~(&r_full);
    assign w_xfer_in  = bus.in_valid && w_in_ready;
    assign w_xfer_out = r_full[r_pres_sel] && bus.vec_ready;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        s1_vec_bank #(
            .M  (M),
            .N  (N),
            .CW (CW)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .i_wr_en (w_xfer_in && (r_fill_sel == 1'(b))),
            .i_data  (bus.in_data),
            .i_last  (bus.in_last),
            .o_close (w_close[b]),
            .o_words (w_words[b]),
            .o_count (w_count[b]),
            .o_short (w_short[b])
        );
    end

    // The closing bank and the presented bank are never the same bank, so
    // a set and a clear cannot collide on one flag. Alternating both
    // pointers keeps presentation in fill order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full     <= 2'b00;
            r_fill_sel <= 1'b0;
            r_pres_sel <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_close[b]) begin
                    r_full[b] <= 1'b1;
                end else if (w_xfer_out && (r_pres_sel == 1'(b))) begin
                    r_full[b] <= 1'b0;
                end
            end
            if (|w_close) begin
                r_fill_sel <= ~r_fill_sel;
            end
            if (w_xfer_out) begin
                r_pres_sel <= ~r_pres_sel;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.vec_valid = r_full[r_pres_sel];
    assign bus.X         = w_words[r_pres_sel];
    assign bus.vec_count = w_count[r_pres_sel];
    assign bus.short_vec = w_short[r_pres_sel];

`else

    loader_state_t  r_state;
    logic           r_vec_valid;
    logic           r_in_ready;
    logic           w_xfer_in;
    logic           w_close;
    logic [M*N-1:0] w_words;
    logic [CW-1:0]  w_count;
    logic           w_short;

    assign w_xfer_in = bus.in_valid && r_in_ready;

    for (genvar b = 0; b < 1; b++) begin : g_bank
        s1_vec_bank #(
            .M  (M),
            .N  (N),
            .CW (CW)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .i_wr_en (w_xfer_in),
            .i_data  (bus.in_data),
            .i_last  (bus.in_last),
            .o_close (w_close),
            .o_words (w_words),
            .o_count (w_count),
            .o_short (w_short)
        );
    end

    // in_ready reopens only the cycle after the vector leaves; the bank is
    // the presented register, so it cannot accept while held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FILL;
            r_vec_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_close) begin
                        r_state     <= HOLD;
                        r_vec_valid <= 1'b1;
                        r_in_ready  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (r_vec_valid && bus.vec_ready) begin
                        r_state     <= FILL;
                        r_vec_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= FILL;
                    r_vec_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.vec_valid = r_vec_valid;
    assign bus.X         = w_words;
    assign bus.vec_count = w_count;
    assign bus.short_vec = w_short;

`endif

endmodule
`default_nettype wire

// File: tb/tb_s1_vec_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_s1_vec_loader
// Purpose  : Directed self-checking bench for s1_vec_loader (M=8, N=32).
// Revision : 1.0  initial release
// ============================================================================
module tb_s1_vec_loader;

    localparam int M  = 8;
    localparam int N  = 32;
    localparam int CW = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    s1_vec_loader_if #(.M(M), .N(N), .CW(CW)) bus ();

    s1_vec_loader #(.M(M), .N(N), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample for one cycle (caller knows in_ready is high).
    task automatic send(input logic [N-1:0] d, input logic last);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++; if (bus.X !== '0) $display("FAIL reset_X got %h want 0", bus.X); else n_pass++;
        n_checks++; if (bus.vec_valid !== 1'b0) $display("FAIL reset_vec_valid got %b want 0", bus.vec_valid); else n_pass++;
        n_checks++; if (bus.vec_count !== 4'd0) $display("FAIL reset_vec_count got %0d want 0", bus.vec_count); else n_pass++;
        n_checks++; if (bus.short_vec !== 1'b0) $display("FAIL reset_short got %b want 0", bus.short_vec); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else n_pass++;
    endtask

    task automatic test_full_vector();
        logic [M*N-1:0] exp;
        logic [N-1:0]   w;
        exp = '0;
        bus.vec_ready = 1'b1;
        for (int k = 1; k <= M; k++) begin
            w = N'(k) << 20;
            exp[N*(k-1) +: N] = w;
            send(w, 1'b0);
            if (k == M-1) begin
                n_checks++; if (bus.vec_valid !== 1'b0) $display("FAIL full_early_valid got %b want 0", bus.vec_valid); else n_pass++;
            end
        end
        n_checks++; if (bus.vec_valid !== 1'b1) $display("FAIL full_valid got %b want 1", bus.vec_valid); else n_pass++;
        n_checks++; if (bus.X[31:0] !== 32'h0010_0000) $display("FAIL full_word0 got %h want 00100000", bus.X[31:0]); else n_pass++;
        n_checks++; if (bus.X[255:224] !== 32'h0080_0000) $display("FAIL full_word7 got %h want 00800000", bus.X[255:224]); else n_pass++;
        n_checks++; if (bus.X !== exp) $display("FAIL full_X got %h want %h", bus.X, exp); else n_pass++;
        n_checks++; if (bus.vec_count !== 4'd8) $display("FAIL full_count got %0d want 8", bus.vec_count); else n_pass++;
        n_checks++; if (bus.short_vec !== 1'b0) $display("FAIL full_short got %b want 0", bus.short_vec); else n_pass++;
        tick();
        n_checks++; if (bus.vec_valid !== 1'b0) $display("FAIL full_drop_valid got %b want 0", bus.vec_valid); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL full_in_ready got %b want 1", bus.in_ready); else n_pass++;
    endtask

    task automatic test_short_vector();
        logic [M*N-1:0] exp;
        exp = {5{32'h0}} << 0;
        exp = {160'h0, 32'hFFF0_0000, 32'hFFF0_0000, 32'hFFF0_0000};
        bus.vec_ready = 1'b0;
        send(32'hFFF0_0000, 1'b0);
        send(32'hFFF0_0000, 1'b0);
        send(32'hFFF0_0000, 1'b1);
        n_checks++; if (bus.vec_valid !== 1'b1) $display("FAIL short_valid got %b want 1", bus.vec_valid); else n_pass++;
        n_checks++; if (bus.X !== exp) $display("FAIL short_X got %h want %h", bus.X, exp); else n_pass++;
        n_checks++; if (bus.vec_count !== 4'd3) $display("FAIL short_count got %0d want 3", bus.vec_count); else n_pass++;
        n_checks++; if (bus.short_vec !== 1'b1) $display("FAIL short_flag got %b want 1", bus.short_vec); else n_pass++;
        bus.vec_ready = 1'b1;
        tick();
        n_checks++; if (bus.vec_valid !== 1'b0) $display("FAIL short_release got %b want 0", bus.vec_valid); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [M*N-1:0] exp;
        logic [M*N-1:0] exp2;
        int bad_ready;
        int bad_x;
        bus.vec_ready = 1'b0;
        for (int k = 0; k < M; k++) begin
            exp[N*k +: N] = 32'h000A_0000 + 32'(k);
            send(32'h000A_0000 + 32'(k), 1'b0);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
        bad_ready = 0;
        bad_x     = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.in_ready !== 1'b0) bad_ready++;
            if (bus.X !== exp || bus.vec_valid !== 1'b1) bad_x++;
        end
        n_checks++; if (bad_ready != 0) $display("FAIL bp_in_ready got %0d high cycles want 0", bad_ready); else n_pass++;
        n_checks++; if (bad_x != 0) $display("FAIL bp_X_stable got %0d changed cycles want 0", bad_x); else n_pass++;
        bus.in_valid  = 1'b0;
        bus.vec_ready = 1'b1;
        tick();
        n_checks++; if (bus.vec_valid !== 1'b0) $display("FAIL bp_release got %b want 0", bus.vec_valid); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_in_ready_back got %b want 1", bus.in_ready); else n_pass++;
        // No held-off sample may have slipped in: a fresh vector lands at slot 0.
        bus.vec_ready = 1'b0;
        for (int k = 0; k < M; k++) begin
            exp2[N*k +: N] = 32'h0000_0100 * 32'(k + 1);
            send(32'h0000_0100 * 32'(k + 1), 1'b0);
        end
        n_checks++; if (bus.X !== exp2) $display("FAIL bp_next_X got %h want %h", bus.X, exp2); else n_pass++;
        bus.vec_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_midfill();
        logic [M*N-1:0] exp;
        bus.vec_ready = 1'b0;
        for (int k = 0; k < 5; k++) send(32'h5555_0000 + 32'(k), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (bus.X !== '0) $display("FAIL rstfill_X got %h want 0", bus.X); else n_pass++;
        n_checks++; if (bus.vec_valid !== 1'b0 || bus.vec_count !== 4'd0 || bus.short_vec !== 1'b0)
            $display("FAIL rstfill_flags got v=%b c=%0d s=%b want 0/0/0", bus.vec_valid, bus.vec_count, bus.short_vec); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rstfill_in_ready got %b want 1", bus.in_ready); else n_pass++;
        for (int k = 0; k < M; k++) begin
            exp[N*k +: N] = 32'h0000_1000 + 32'(k);
            send(32'h0000_1000 + 32'(k), 1'b0);
        end
        n_checks++; if (bus.X !== exp || bus.vec_count !== 4'd8)
            $display("FAIL rstfill_fresh got %h cnt %0d want %h cnt 8", bus.X, bus.vec_count, exp); else n_pass++;
        // Reset while held with vec_ready high: the vector is simply lost.
        bus.vec_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (bus.vec_valid !== 1'b0 || bus.X !== '0)
            $display("FAIL rsthold got v=%b X=%h want 0/0", bus.vec_valid, bus.X); else n_pass++;
    endtask

    task automatic test_stray_last();
        logic [M*N-1:0] exp;
        bus.vec_ready = 1'b0;
        for (int k = 0; k < M; k++) exp[N*k +: N] = 32'h0002_0000 + 32'(k);
        send(exp[31:0], 1'b0);
        send(exp[63:32], 1'b0);
        bus.in_last = 1'b1;
        bus.in_data = 32'hBAD0_BAD0;
        tick();
        bus.in_last = 1'b0;
        for (int k = 2; k < M; k++) begin
            send(exp[N*k +: N], 1'b0);
            if (k == M-2) begin
                n_checks++; if (bus.vec_valid !== 1'b0) $display("FAIL stray_early_valid got %b want 0", bus.vec_valid); else n_pass++;
            end
        end
        n_checks++; if (bus.vec_valid !== 1'b1 || bus.vec_count !== 4'd8 || bus.short_vec !== 1'b0)
            $display("FAIL stray_close got v=%b c=%0d s=%b want 1/8/0", bus.vec_valid, bus.vec_count, bus.short_vec); else n_pass++;
        n_checks++; if (bus.X !== exp) $display("FAIL stray_X got %h want %h", bus.X, exp); else n_pass++;
        bus.vec_ready = 1'b1;
        tick();
    endtask

    task automatic test_redundant_last();
        bus.vec_ready = 1'b0;
        for (int k = 0; k < M; k++) send(32'h0003_0000 + 32'(k), (k == M-1));
        n_checks++; if (bus.vec_valid !== 1'b1 || bus.vec_count !== 4'd8 || bus.short_vec !== 1'b0)
            $display("FAIL redlast got v=%b c=%0d s=%b want 1/8/0", bus.vec_valid, bus.vec_count, bus.short_vec); else n_pass++;
        n_checks++; if (bus.X[255:224] !== 32'h0003_0007) $display("FAIL redlast_word7 got %h want 00030007", bus.X[255:224]); else n_pass++;
        bus.vec_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        int   vec_seen;
        int   last_cyc;
        int   bad_ready;
        int   bad_gap;
        int   bad_x;
        logic [M*N-1:0] exp;
        bus.vec_ready = 1'b1;
        vec_seen  = 0;
        last_cyc  = 0;
        bad_ready = 0;
        bad_gap   = 0;
        bad_x     = 0;
        for (int c = 0; c < 3*M + 2; c++) begin
            if (c < 3*M) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 32'h0100_0000 + 32'(c);
                if (bus.in_ready !== 1'b1) bad_ready++;
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            if (bus.vec_valid === 1'b1) begin
                for (int k = 0; k < M; k++) exp[N*k +: N] = 32'h0100_0000 + 32'(vec_seen*M + k);
                if (bus.X !== exp) bad_x++;
                if (vec_seen > 0 && (c - last_cyc) != M) bad_gap++;
                last_cyc = c;
                vec_seen++;
            end
        end
        bus.in_valid = 1'b0;
        n_checks++; if (bad_ready != 0) $display("FAIL dbuf_in_ready got %0d low cycles want 0", bad_ready); else n_pass++;
        n_checks++; if (vec_seen != 3) $display("FAIL dbuf_count got %0d vectors want 3", vec_seen); else n_pass++;
        n_checks++; if (bad_x != 0) $display("FAIL dbuf_order got %0d wrong vectors want 0", bad_x); else n_pass++;
        n_checks++; if (bad_gap != 0) $display("FAIL dbuf_spacing got %0d bad gaps want 0", bad_gap); else n_pass++;
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b1;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.vec_ready = 1'b0;
        test_reset();
        test_full_vector();
        test_short_vector();
`ifndef VEC_LOADER_DBUF_EN
        test_backpressure();
`endif
        test_reset_midfill();
        test_stray_last();
        test_redundant_last();
`ifdef VEC_LOADER_DBUF_EN
        test_back_to_back();
`endif
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
